// File: rtl/sd_stream_pkg.sv
// Shared types and constants for the SD-card-to-sample-FIFO block sequencer.
package sd_stream_pkg;

    localparam int unsigned SD_BLOCK_BYTES = 512;
    localparam int unsigned SD_ADDR_W      = 32;
    localparam int unsigned SD_FIFO_CNT_W  = 11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ROOM = 3'd1,
        ISSUE     = 3'd2,
        STREAM    = 3'd3,
        ADVANCE   = 3'd4,
        DONE      = 3'd5
    } sd_stream_state_t;

    // Streaming is in progress anywhere between leaving IDLE and reaching DONE.
    function automatic logic state_is_busy(input sd_stream_state_t st);
        return (st != IDLE) && (st != DONE);
    endfunction

endpackage

// File: rtl/sd_stream_sequencer_if.sv
// Bus bundle between the sequencer, sd_controller and the sample FIFO.
// slave is the sequencer's view, master the environment's view.
interface sd_stream_sequencer_if;
    import sd_stream_pkg::*;

    logic                     play_in;
    logic                     sd_ready_in;
    logic                     sd_byte_available_in;
    logic                     sd_rd_out;
    logic [SD_ADDR_W-1:0]     sd_addr_out;
    logic [SD_FIFO_CNT_W-1:0] fifo_count_in;
    logic                     fifo_wr_en_out;
    logic                     busy_out;
    logic                     done_out;
    logic [15:0]              blocks_read_out;

    modport slave (
        input  play_in, sd_ready_in, sd_byte_available_in, fifo_count_in,
        output sd_rd_out, sd_addr_out, fifo_wr_en_out, busy_out, done_out,
               blocks_read_out
    );

    modport master (
        output play_in, sd_ready_in, sd_byte_available_in, fifo_count_in,
        input  sd_rd_out, sd_addr_out, fifo_wr_en_out, busy_out, done_out,
               blocks_read_out
    );

endinterface

// File: rtl/sd_stream_sequencer_edge_pulse.sv
// Rising-edge detector: rise is high while sig is high and its registered copy is low.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_d_r;

    // Registered copy of the input, one cycle behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_d_r <= 1'b0;
        end else begin
            sig_d_r <= sig;
        end
    end

    assign rise = sig & ~sig_d_r;

endmodule

// File: rtl/sd_stream_sequencer.sv
// Issues 512-byte SD reads into the sample FIFO when it has room for a whole block.
// Optional feature: SD_STREAM_LOOP_EN wraps playback to START_ADDR instead of stopping in DONE.
module sd_stream_sequencer
    import sd_stream_pkg::*;
#(
    parameter logic [31:0] START_ADDR  = 32'h0000_0000,
    parameter logic [31:0] END_ADDR    = 32'h0100_0000,
    parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES,
    parameter int unsigned FIFO_DEPTH  = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    sd_stream_sequencer_if.slave  bus
);

    localparam logic [11:0] DEPTH_12  = 12'(FIFO_DEPTH);
    localparam logic [11:0] BLOCK_12  = 12'(BLOCK_BYTES);
    localparam logic [9:0]  LAST_BYTE = 10'(BLOCK_BYTES - 1);
    localparam logic [31:0] BLOCK_32  = 32'(BLOCK_BYTES);

    sd_stream_state_t state_r;
    sd_stream_state_t next_state_s;

    logic [9:0]  byte_cnt_r;
    logic        sd_rd_r;
    logic [31:0] addr_r;
    logic        wr_en_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] blocks_r;

    logic        rise_s;
    logic [11:0] free_s;
    logic        room_s;
    logic        byte_hit_s;
    logic        last_byte_s;
    logic [31:0] next_addr_s;
    logic        at_end_s;
    logic        advance_fire_s;

    edge_pulse u_byte_edge (
        .clk  (clk_in),
        .rst  (rst_in),
        .sig  (bus.sd_byte_available_in),
        .rise (rise_s)
    );

    // Occupancy above the depth would borrow, so it is treated as no room.
    assign free_s = DEPTH_12 - {1'b0, bus.fifo_count_in};
    assign room_s = ({1'b0, bus.fifo_count_in} <= DEPTH_12) && (free_s >= BLOCK_12);

    assign byte_hit_s     = (state_r == STREAM) && rise_s;
    assign last_byte_s    = byte_hit_s && (byte_cnt_r == LAST_BYTE);
    assign next_addr_s    = addr_r + BLOCK_32;
    assign at_end_s       = (next_addr_s == END_ADDR);
    assign advance_fire_s = (state_r == ADVANCE) && bus.sd_ready_in;

    // Next-state logic; a started block always runs to ADVANCE before play_in is honoured.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.play_in) begin
                    next_state_s = WAIT_ROOM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_ROOM: begin
                if (!bus.play_in) begin
                    next_state_s = IDLE;
                end else if (bus.sd_ready_in && room_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = WAIT_ROOM;
                end
            end
            ISSUE: begin
                if (!bus.sd_ready_in) begin
                    next_state_s = STREAM;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            STREAM: begin
                if (last_byte_s) begin
                    next_state_s = ADVANCE;
                end else begin
                    next_state_s = STREAM;
                end
            end
            ADVANCE: begin
                if (!bus.sd_ready_in) begin
                    next_state_s = ADVANCE;
`ifdef SD_STREAM_LOOP_EN
                end else if (bus.play_in) begin
                    next_state_s = WAIT_ROOM;
`else
                end else if (at_end_s) begin
                    next_state_s = DONE;
                end else if (bus.play_in) begin
                    next_state_s = WAIT_ROOM;
`endif
                end else begin
                    next_state_s = IDLE;
                end
            end
            DONE: begin
                next_state_s = DONE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; status outputs follow the next state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= IDLE;
            byte_cnt_r <= 10'd0;
            sd_rd_r    <= 1'b0;
            addr_r     <= START_ADDR;
            wr_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            blocks_r   <= 16'd0;
        end else begin
            state_r <= next_state_s;
            sd_rd_r <= (next_state_s == ISSUE);
            busy_r  <= state_is_busy(next_state_s);
            done_r  <= (next_state_s == DONE);
            wr_en_r <= byte_hit_s;

            if ((state_r != STREAM) && (next_state_s == STREAM)) begin
                byte_cnt_r <= 10'd0;
            end else if (byte_hit_s) begin
                byte_cnt_r <= byte_cnt_r + 10'd1;
            end else begin
                byte_cnt_r <= byte_cnt_r;
            end

            if (advance_fire_s) begin
                blocks_r <= blocks_r + 16'd1;
`ifdef SD_STREAM_LOOP_EN
                addr_r   <= at_end_s ? START_ADDR : next_addr_s;
`else
                addr_r   <= next_addr_s;
`endif
            end else begin
                blocks_r <= blocks_r;
                addr_r   <= addr_r;
            end
        end
    end

    assign bus.sd_rd_out       = sd_rd_r;
    assign bus.sd_addr_out     = addr_r;
    assign bus.fifo_wr_en_out  = wr_en_r;
    assign bus.busy_out        = busy_r;
    assign bus.done_out        = done_r;
    assign bus.blocks_read_out = blocks_r;

endmodule

// File: tb/tb_sd_stream_sequencer.sv
// Scoreboard bench: an sd_controller model feeds bytes, a monitor checks reads and FIFO writes.
module tb_sd_stream_sequencer;
    import sd_stream_pkg::*;

    localparam logic [31:0] START = 32'd0;
    localparam logic [31:0] ENDA  = 32'd1024;
    localparam int          BLK   = 512;
    localparam int          NBLK  = 2;
    localparam int          LIMIT = 12000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sd_stream_sequencer_if bus();

    sd_stream_sequencer #(
        .START_ADDR  (START),
        .END_ADDR    (ENDA),
        .BLOCK_BYTES (BLK),
        .FIFO_DEPTH  (1024)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #20 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wr_q[$];

    int ctrl_hi = 0;
    int ctrl_lo = 0;
    bit ctrl_abort = 1'b0;
    int junk_req = 0;
    int junk_done = 0;
    int bytes_served = 0;
    int reads_served = 0;
    bit ctrl_busy = 1'b0;

    int wr_pulses = 0;
    int rd_pulses = 0;
    logic rd_prev = 1'b0;

    int model_blk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: the k-th read after reset targets block k of the region, wrapping when looping.
    function automatic logic [31:0] model_addr(input int k);
        return START + 32'((k % NBLK) * BLK);
    endfunction

    task automatic expect_read();
        exp_rd_q.push_back(model_addr(model_blk));
        model_blk++;
    endtask

    task automatic do_reset();
        bus.play_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_rd_q.delete();
        exp_wr_q.delete();
        model_blk = 0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_reads(input int target);
        int n = 0;
        while (reads_served < target && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("read_issued", reads_served, target);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (bytes_served < target && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("bytes_reached", (bytes_served >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.busy_out && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({name, "_idle"}, bus.busy_out, 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_rd"}, bus.sd_rd_out, 0);
        check({name, "_addr"}, bus.sd_addr_out, START);
        check({name, "_wr"}, bus.fifo_wr_en_out, 0);
        check({name, "_busy"}, bus.busy_out, 0);
        check({name, "_done"}, bus.done_out, 0);
        check({name, "_blocks"}, bus.blocks_read_out, 0);
    endtask

    // sd_controller model: ready drops on a read, then 512 strobed bytes with random spacing.
    initial begin : ctrl
        logic [31:0] blk_addr;
        int hi;
        int lo;
        bus.sd_ready_in = 1'b1;
        bus.sd_byte_available_in = 1'b0;
        forever begin
            @(negedge clk);
            if (junk_done != junk_req) begin
                bus.sd_byte_available_in = 1'b1;
                repeat (3) @(negedge clk);
                bus.sd_byte_available_in = 1'b0;
                repeat (2) @(negedge clk);
                junk_done++;
            end else if (bus.sd_rd_out && !ctrl_abort) begin
                blk_addr = bus.sd_addr_out;
                ctrl_busy = 1'b1;
                bytes_served = 0;
                reads_served++;
                bus.sd_ready_in = 1'b0;
                repeat (2) @(negedge clk);
                for (int i = 0; i < BLK; i++) begin
                    if (ctrl_abort) break;
                    hi = (ctrl_hi != 0) ? ctrl_hi : int'($urandom_range(6, 1));
                    lo = (ctrl_lo != 0) ? ctrl_lo : int'($urandom_range(3, 1));
                    bus.sd_byte_available_in = 1'b1;
                    exp_wr_q.push_back(blk_addr);
                    repeat (hi) @(negedge clk);
                    bus.sd_byte_available_in = 1'b0;
                    bytes_served++;
                    repeat (lo) @(negedge clk);
                end
                bus.sd_ready_in = 1'b1;
                ctrl_busy = 1'b0;
            end
        end
    end

    // Monitor: every read request and FIFO write is matched against the scoreboard queues.
    initial begin : mon
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.sd_rd_out && !rd_prev) begin
                    rd_pulses++;
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_rd", bus.sd_rd_out, 0);
                    end else begin
                        check("rd_addr", bus.sd_addr_out, exp_rd_q.pop_front());
                    end
                end
                if (bus.fifo_wr_en_out) begin
                    wr_pulses++;
                    if (exp_wr_q.size() == 0) begin
                        check("unexpected_wr", bus.fifo_wr_en_out, 0);
                    end else begin
                        check("wr_block_addr", bus.sd_addr_out, exp_wr_q.pop_front());
                    end
                end
            end
            rd_prev = bus.sd_rd_out;
        end
    end

    initial begin : watchdog
        #(40 * 95000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin : main
        int wr_base;
        int rd_base;
        int rs_base;
        bus.play_in = 1'b0;
        bus.fifo_count_in = 11'd0;

        // Reset values
        do_reset();
        check_reset_values("reset");

        // Single block at 4 cycles per byte, play dropped once the read is accepted
        ctrl_hi = 2;
        ctrl_lo = 2;
        wr_base = wr_pulses;
        expect_read();
        bus.play_in = 1'b1;
        @(negedge clk);
        check("play_latency_busy", bus.busy_out, 1);
        wait_reads(1);
        bus.play_in = 1'b0;
        wait_idle("single");
        check("single_writes", wr_pulses - wr_base, BLK);
        check("single_addr", bus.sd_addr_out, 32'd512);
        check("single_blocks", bus.blocks_read_out, 1);
        check("single_done", bus.done_out, 0);

        // Room gating: 513 bytes occupied blocks the read, 512 lets it through next cycle
        ctrl_hi = 0;
        ctrl_lo = 0;
        do_reset();
        rd_base = rd_pulses;
        rs_base = reads_served;
        bus.fifo_count_in = 11'd513;
        bus.play_in = 1'b1;
        repeat (40) @(negedge clk);
        check("gate_no_rd", rd_pulses - rd_base, 0);
        check("gate_rd_low", bus.sd_rd_out, 0);
        check("gate_busy", bus.busy_out, 1);
        bus.fifo_count_in = 11'd512;
        expect_read();
        @(negedge clk);
        check("gate_rd_high", bus.sd_rd_out, 1);
        bus.play_in = 1'b0;
        wait_reads(rs_base + 1);
        wait_idle("gate");
        bus.fifo_count_in = 11'd0;
        check("gate_blocks", bus.blocks_read_out, 1);

        // Pause after byte 100, resume, then the end of the region
        do_reset();
        wr_base = wr_pulses;
        rs_base = reads_served;
        expect_read();
        bus.play_in = 1'b1;
        wait_reads(rs_base + 1);
        wait_bytes(100);
        bus.play_in = 1'b0;
        wait_idle("pause");
        check("pause_writes", wr_pulses - wr_base, BLK);
        check("pause_addr", bus.sd_addr_out, 32'd512);
        check("pause_blocks", bus.blocks_read_out, 1);
        check("pause_done", bus.done_out, 0);
        expect_read();
`ifdef SD_STREAM_LOOP_EN
        expect_read();
        bus.play_in = 1'b1;
        wait_reads(rs_base + 3);
        bus.play_in = 1'b0;
        wait_idle("loop");
        check("loop_addr", bus.sd_addr_out, 32'd512);
        check("loop_blocks", bus.blocks_read_out, 3);
        check("loop_done", bus.done_out, 0);
`else
        bus.play_in = 1'b1;
        wait_reads(rs_base + 2);
        wait_idle("end");
        check("end_done", bus.done_out, 1);
        check("end_addr", bus.sd_addr_out, ENDA);
        check("end_blocks", bus.blocks_read_out, 2);
        rd_base = rd_pulses;
        repeat (100) @(negedge clk);
        check("end_no_more_rd", rd_pulses - rd_base, 0);
        check("end_done_sticky", bus.done_out, 1);
        check("end_busy", bus.busy_out, 0);
        bus.play_in = 1'b0;
`endif

        // Long strobe: 6 cycles high per byte, still one write per byte
        do_reset();
        ctrl_hi = 6;
        wr_base = wr_pulses;
        rs_base = reads_served;
        expect_read();
        bus.play_in = 1'b1;
        wait_reads(rs_base + 1);
        bus.play_in = 1'b0;
        wait_idle("long");
        check("long_writes", wr_pulses - wr_base, BLK);
        check("long_blocks", bus.blocks_read_out, 1);
        ctrl_hi = 0;

        // Asynchronous reset after byte 300
        do_reset();
        rs_base = reads_served;
        expect_read();
        bus.play_in = 1'b1;
        wait_reads(rs_base + 1);
        wait_bytes(300);
        bus.play_in = 1'b0;
        ctrl_abort = 1'b1;
        #5;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        begin
            int n = 0;
            while (ctrl_busy && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            check("ctrl_abort", ctrl_busy, 0);
        end
        exp_wr_q.delete();
        exp_rd_q.delete();
        model_blk = 0;
        @(negedge clk);
        rst = 1'b0;
        ctrl_abort = 1'b0;
        wr_base = wr_pulses;
        rd_base = rd_pulses;
        junk_req = junk_req + 4;
        begin
            int n = 0;
            while (junk_done != junk_req && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            check("junk_done", junk_done, junk_req);
        end
        check("after_rst_no_wr", wr_pulses - wr_base, 0);
        check("after_rst_no_rd", rd_pulses - rd_base, 0);
        check("after_rst_busy", bus.busy_out, 0);
        rs_base = reads_served;
        expect_read();
        bus.play_in = 1'b1;
        wait_reads(rs_base + 1);
        bus.play_in = 1'b0;
        wait_idle("replay");
        check("replay_writes", wr_pulses - wr_base, BLK);
        check("replay_addr", bus.sd_addr_out, 32'd512);
        check("replay_blocks", bus.blocks_read_out, 1);

        repeat (5) @(negedge clk);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        check("wr_queue_empty", exp_wr_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
